// File: rtl/d_reg_write_arbiter_pkg.sv
// d_reg_write_arbiter_pkg: shared op and FSM state encodings for the register write arbiter.
package d_reg_write_arbiter_pkg;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_HOLD  = 2'b11;
   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_WRITE  = 2'b01;
   localparam logic [1:0] S_ACK    = 2'b10;
endpackage

// File: rtl/d_reg_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req bit at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt
);
   logic [N-1:0] hi;
   logic [N-1:0] sel;
   // Prefer requesters at or above ptr; fall back to the lowest set bit overall on wrap.
   assign hi  = req & ~((N'(1) << ptr) - N'(1));
   assign sel = (|hi) ? hi : req;
   assign gnt = sel & (~sel + N'(1));
endmodule

// File: rtl/d_reg_write_arbiter.sv
// d_reg_write_arbiter: round-robin shared write port for one D-register (q/nq),
// IDLE -> WRITE -> ACK transaction per granted command.
module d_reg_write_arbiter
   import d_reg_write_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     op,
   input  logic [WIDTH*N_REQ-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic                   busy,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       nq
);
   localparam int PW = $clog2(N_REQ);
   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d, arb_gnt;
   logic [PW-1:0]    ptr_q, ptr_d, win;
   logic [1:0]       op_q, op_d, op_sel;
   logic [WIDTH-1:0] wdata_q, wdata_d, wdata_sel, q_q, q_d;

   rr_arbiter #(.N(N_REQ)) u_arb (.req(req), .ptr(ptr_q), .gnt(arb_gnt));

   // One-hot grant lets the command mux be a plain AND-OR.
   always_comb begin
      op_sel    = '0;
      wdata_sel = '0;
      win       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         op_sel    |= op[2*i +: 2] & {2{arb_gnt[i]}};
         wdata_sel |= wdata[WIDTH*i +: WIDTH] & {WIDTH{arb_gnt[i]}};
         if (gnt_q[i]) win = PW'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      ptr_d   = ptr_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      q_d     = q_q;
      case (state_q)
         S_IDLE: if (|req) begin
            gnt_d   = arb_gnt;
            op_d    = op_sel;
            wdata_d = wdata_sel;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            q_d     = (op_q == OP_LOAD)  ? wdata_q :
                      (op_q == OP_SET)   ? '1 :
                      (op_q == OP_CLEAR) ? '0 : q_q;
            ack_d   = gnt_q;
            state_d = S_ACK;
         end
         S_ACK: begin
            gnt_d   = '0;
            ack_d   = '0;
            ptr_d   = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            ack_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         ack_q   <= '0;
         ptr_q   <= '0;
         op_q    <= OP_LOAD;
         wdata_q <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         q_q     <= q_d;
      end
   end

   assign gnt  = gnt_q;
   assign ack  = ack_q;
   assign busy = (state_q != S_IDLE);
   assign q    = q_q;
   assign nq   = ~q_q;
endmodule

// File: tb/tb_d_reg_write_arbiter.sv
// tb_d_reg_write_arbiter: scenario tasks plus an ack-driven scoreboard for d_reg_write_arbiter.
module tb_d_reg_write_arbiter;
   import d_reg_write_arbiter_pkg::*;
   typedef struct packed {
      logic [3:0] ack;
      logic [3:0] q;
   } exp_t;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic [7:0] op;
   logic [15:0] wdata;
   logic [3:0] gnt, ack, q, nq;
   logic       busy;
   logic [3:0] mq;
   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;

   d_reg_write_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .op(op), .wdata(wdata),
      .gnt(gnt), .ack(ack), .busy(busy), .q(q), .nq(nq)
   );

   always #5 clk = ~clk;

   // Every ack is matched against the oldest expected write; grant must stay one-hot.
   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         total += 1;
         if ((gnt & (gnt - 4'd1)) != 4'd0) begin
            bad += 1;
            $display("FAIL gnt_onehot: got %b want at most one bit", gnt);
         end
         total += 1;
         if (nq !== ~q) begin
            bad += 1;
            $display("FAIL nq_inv: got %h want %h", nq, ~q);
         end
         if (ack !== 4'd0) begin
            total += 1;
            if (sb.size() == 0) begin
               bad += 1;
               $display("FAIL sb_unexpected_ack: got ack=%b want none", ack);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (ack !== e.ack || q !== e.q) begin
                  bad += 1;
                  $display("FAIL sb_ack_q: got ack=%b q=%h want ack=%b q=%h", ack, q, e.ack, e.q);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int i, input logic [1:0] o, input logic [3:0] d);
      mq = (o == OP_LOAD) ? d : (o == OP_SET) ? 4'hF : (o == OP_CLEAR) ? 4'h0 : mq;
      sb.push_back({4'(1 << i), mq});
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req = 4'b1111;
      op = 8'h1B;
      wdata = 16'hFFFF;
      mq = 4'h0;
      repeat (3) @(posedge clk);
      #2;
      total += 1; if (q !== 4'h0) begin bad += 1; $display("FAIL reset_q: got %h want 0", q); end
      total += 1; if (nq !== 4'hF) begin bad += 1; $display("FAIL reset_nq: got %h want f", nq); end
      total += 1; if (gnt !== 4'h0) begin bad += 1; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total += 1; if (ack !== 4'h0) begin bad += 1; $display("FAIL reset_ack: got %b want 0000", ack); end
      total += 1; if (busy !== 1'b0) begin bad += 1; $display("FAIL reset_busy: got %b want 0", busy); end
      req = 4'b0000;
      op = 8'h00;
      wdata = 16'h0000;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      req = 4'b1111;
      op = 8'h00;
      wdata = 16'h3210;
      for (int k = 0; k < 5; k++) push_exp(k % 4, OP_LOAD, 4'(k % 4));
      for (int k = 0; k < 5; k++) begin
         step();
         eg = 4'(1 << (k % 4));
         total += 1;
         if (gnt !== eg) begin bad += 1; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, eg); end
         if (k == 4) req = 4'b0000;
         step();
         step();
      end
   endtask

   task automatic test_wrap();
      req = 4'b1000;
      op = 8'h00;
      wdata = 16'h7000;
      push_exp(3, OP_LOAD, 4'h7);
      step();
      total += 1; if (gnt !== 4'b1000) begin bad += 1; $display("FAIL wrap_gnt3: got %b want 1000", gnt); end
      req = 4'b1001;
      wdata = 16'h7006;
      push_exp(0, OP_LOAD, 4'h6);
      push_exp(3, OP_LOAD, 4'h7);
      step();
      step();
      step();
      total += 1; if (gnt !== 4'b0001) begin bad += 1; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
      step();
      step();
      step();
      total += 1; if (gnt !== 4'b1000) begin bad += 1; $display("FAIL wrap_gnt3b: got %b want 1000", gnt); end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_single_load();
      req = 4'b0100;
      op[5:4] = OP_LOAD;
      wdata[11:8] = 4'hA;
      push_exp(2, OP_LOAD, 4'hA);
      step();
      total += 1; if (gnt !== 4'b0100) begin bad += 1; $display("FAIL load_gnt: got %b want 0100", gnt); end
      total += 1; if (busy !== 1'b1) begin bad += 1; $display("FAIL load_busy: got %b want 1", busy); end
      total += 1; if (ack !== 4'b0000) begin bad += 1; $display("FAIL load_early_ack: got %b want 0000", ack); end
      req = 4'b0000;
      step();
      total += 1; if (ack !== 4'b0100) begin bad += 1; $display("FAIL load_ack: got %b want 0100", ack); end
      total += 1; if (q !== 4'hA) begin bad += 1; $display("FAIL load_q: got %h want a", q); end
      step();
      total += 1; if (busy !== 1'b0) begin bad += 1; $display("FAIL load_idle_busy: got %b want 0", busy); end
      total += 1; if (gnt !== 4'b0000) begin bad += 1; $display("FAIL load_idle_gnt: got %b want 0000", gnt); end
   endtask

   task automatic test_ops();
      logic [1:0] ops [4];
      logic [3:0] dat [4];
      ops = '{OP_SET, OP_CLEAR, OP_LOAD, OP_HOLD};
      dat = '{4'h0, 4'h0, 4'h9, 4'h5};
      for (int k = 0; k < 4; k++) begin
         req = 4'b0001;
         op[1:0] = ops[k];
         wdata[3:0] = dat[k];
         push_exp(0, ops[k], dat[k]);
         step();
         total += 1;
         if (gnt !== 4'b0001) begin bad += 1; $display("FAIL op%0d_gnt: got %b want 0001", k, gnt); end
         req = 4'b0000;
         step();
         step();
         total += 1;
         if (q !== mq || nq !== ~mq) begin
            bad += 1;
            $display("FAIL op%0d_q: got q=%h nq=%h want q=%h nq=%h", k, q, nq, mq, ~mq);
         end
      end
   endtask

   task automatic test_capture();
      req = 4'b0010;
      op[3:2] = OP_LOAD;
      wdata[7:4] = 4'hB;
      push_exp(1, OP_LOAD, 4'hB);
      step();
      total += 1; if (gnt !== 4'b0010) begin bad += 1; $display("FAIL cap_gnt: got %b want 0010", gnt); end
      op[3:2] = OP_SET;
      wdata[7:4] = 4'h4;
      req = 4'b0000;
      step();
      total += 1; if (ack !== 4'b0010) begin bad += 1; $display("FAIL cap_ack: got %b want 0010", ack); end
      step();
      total += 1; if (q !== 4'hB) begin bad += 1; $display("FAIL cap_q: got %h want b", q); end
   endtask

   task automatic test_async_reset();
      req = 4'b0100;
      op[5:4] = OP_LOAD;
      wdata[11:8] = 4'hC;
      step();
      total += 1; if (gnt !== 4'b0100) begin bad += 1; $display("FAIL ar_gnt: got %b want 0100", gnt); end
      #1 reset_n = 1'b0;
      #1;
      total += 1; if (q !== 4'h0) begin bad += 1; $display("FAIL ar_q: got %h want 0", q); end
      total += 1; if (gnt !== 4'h0) begin bad += 1; $display("FAIL ar_gnt_clr: got %b want 0000", gnt); end
      total += 1; if (busy !== 1'b0) begin bad += 1; $display("FAIL ar_busy: got %b want 0", busy); end
      step();
      total += 1; if (ack !== 4'h0) begin bad += 1; $display("FAIL ar_ack_in_reset: got %b want 0000", ack); end
      req = 4'b0000;
      reset_n = 1'b1;
      mq = 4'h0;
      for (int k = 0; k < 3; k++) begin
         step();
         total += 1;
         if (ack !== 4'h0 || q !== 4'h0) begin
            bad += 1;
            $display("FAIL ar_after%0d: got ack=%b q=%h want ack=0000 q=0", k, ack, q);
         end
      end
      total += 1;
      if (sb.size() != 0) begin bad += 1; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_single_load();
      test_ops();
      test_capture();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
